// File: rtl/afifo_pkg.sv
// afifo_pkg
// Shared definitions for the asynchronous FIFO controllers (write and read side).
//   ASIZE_DEF : default FIFO address width (depth = 2**ASIZE_DEF)
//   bin2gray  : binary-to-Gray conversion. It works on 32 bits, so callers cast
//               their pointer width in and out.
package afifo_pkg;

    localparam int ASIZE_DEF = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// gray2bin
// Pure combinational Gray-to-binary conversion. Each binary bit is the XOR of
// all Gray bits at or above its position.
//   gray : W-bit Gray-coded input
//   bin  : W-bit binary output
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule

// File: rtl/afifo_wr_ctrl.sv
// afifo_wr_ctrl
// Write-side pointer and flag controller for a dual-clock FIFO.
//   l_clk, l_rst : write-domain clock, asynchronous active-low reset
//   push         : write request, one word per cycle
//   ovf_clr      : clears the sticky overflow flag
//   wq2_rptr     : read pointer in Gray code, already synchronized into l_clk
//   wen, waddr   : RAM write strobe and address
//   wptr         : registered Gray write pointer sent to the read domain
//   full, almost_full, overflow, wcount : registered status
module afifo_wr_ctrl
    import afifo_pkg::*;
#(
    parameter int ASIZE    = ASIZE_DEF,
    parameter int AF_LEVEL = (1 << ASIZE) - 2
) (
    input  logic             l_clk,
    input  logic             l_rst,
    input  logic             push,
    input  logic             ovf_clr,
    input  logic [ASIZE:0]   wq2_rptr,
    output logic             wen,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic [ASIZE:0]   wcount
);

    localparam logic [ASIZE:0] AF_THRESH = (ASIZE+1)'(AF_LEVEL);

    logic [ASIZE:0] wbin;
    logic [ASIZE:0] wbin_next;
    logic [ASIZE:0] wgray_next;
    logic [ASIZE:0] rbin;
    logic [ASIZE:0] occ_next;
    logic [ASIZE:0] full_pattern;

    // Gating with l_rst keeps the RAM strobe low while reset is held.
    assign wen        = push & ~full & l_rst;
    assign waddr      = wbin[ASIZE-1:0];
    assign wbin_next  = wbin + (ASIZE+1)'(wen);
    assign wgray_next = (ASIZE+1)'(bin2gray(32'(wbin_next)));

    gray2bin #(
        .W (ASIZE+1)
    ) u_rptr_bin (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    assign occ_next = wbin_next - rbin;

    // In Gray code, "full" means the top two bits are inverted relative to the
    // read pointer and the rest are equal. The extra MSB tells full from empty
    // across the wrap.
    assign full_pattern = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};

    always_ff @(posedge l_clk or negedge l_rst) begin
        if (!l_rst) begin
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            wcount      <= '0;
        end else begin
            wbin        <= wbin_next;
            wptr        <= wgray_next;
            full        <= (wgray_next == full_pattern);
            almost_full <= (occ_next >= AF_THRESH);
            wcount      <= occ_next;
            // A rejected push takes priority over a clear on the same edge.
            if (push && full)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// tb_afifo_wr_ctrl
// Self-checking bench for afifo_wr_ctrl with ASIZE = 2 and AF_LEVEL = 3.
module tb_afifo_wr_ctrl;

    logic       l_clk;
    logic       l_rst;
    logic       push;
    logic       ovf_clr;
    logic [2:0] wq2_rptr;
    logic       wen;
    logic [1:0] waddr;
    logic [2:0] wptr;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic [2:0] wcount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] wptr;
        logic       full;
        logic       af;
        logic       ovf;
        logic [2:0] wcount;
    } exp_t;

    typedef struct {
        logic       push;
        logic       clr;
        logic [2:0] rptr;
        logic       wen;
        logic [1:0] waddr;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    afifo_wr_ctrl #(
        .ASIZE    (2),
        .AF_LEVEL (3)
    ) dut (
        .l_clk       (l_clk),
        .l_rst       (l_rst),
        .push        (push),
        .ovf_clr     (ovf_clr),
        .wq2_rptr    (wq2_rptr),
        .wen         (wen),
        .waddr       (waddr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .wcount      (wcount)
    );

    initial l_clk = 1'b0;
    always #5 l_clk = ~l_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".wptr"},   wptr,        e.wptr);
        chk({tag, ".full"},   full,        e.full);
        chk({tag, ".af"},     almost_full, e.af);
        chk({tag, ".ovf"},    overflow,    e.ovf);
        chk({tag, ".wcount"}, wcount,      e.wcount);
    endtask

    // Called #1 after a rising edge: drive, check the combinational outputs,
    // queue the post-edge expectation, then take the edge and compare.
    task automatic drive_cycle(input string tag, input logic p, input logic c,
                               input logic [2:0] r, input logic ew,
                               input logic [1:0] ea, input exp_t e);
        push     = p;
        ovf_clr  = c;
        wq2_rptr = r;
        #1;
        chk({tag, ".wen"},   wen,   ew);
        chk({tag, ".waddr"}, waddr, ea);
        sb.push_back(e);
        @(posedge l_clk);
        #1;
        check_sb(tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wen"},    wen,         1'b0);
        chk({tag, ".waddr"},  waddr,       2'd0);
        chk({tag, ".wptr"},   wptr,        3'd0);
        chk({tag, ".full"},   full,        1'b0);
        chk({tag, ".af"},     almost_full, 1'b0);
        chk({tag, ".ovf"},    overflow,    1'b0);
        chk({tag, ".wcount"}, wcount,      3'd0);
    endtask

    function automatic exp_t mk(input logic [2:0] wp, input logic f, input logic af,
                                input logic ov, input logic [2:0] wc);
        exp_t e;
        e.wptr = wp; e.full = f; e.af = af; e.ovf = ov; e.wcount = wc;
        return e;
    endfunction

    function automatic vec_t mv(input logic p, input logic c, input logic [2:0] r,
                                input logic w, input logic [1:0] a, input exp_t e);
        vec_t v;
        v.push = p; v.clr = c; v.rptr = r; v.wen = w; v.waddr = a; v.e = e;
        return v;
    endfunction

    initial begin
        logic [2:0] d1, d2, gexp;
        int         cnt;

        //            push clr rptr  wen waddr       wptr    full af ovf wcount
        vecs[0]  = mv(1, 0, 3'b000, 1, 2'd0, mk(3'b001, 0, 0, 0, 3'd1));
        vecs[1]  = mv(1, 0, 3'b000, 1, 2'd1, mk(3'b011, 0, 0, 0, 3'd2));
        vecs[2]  = mv(1, 0, 3'b000, 1, 2'd2, mk(3'b010, 0, 1, 0, 3'd3));
        vecs[3]  = mv(1, 0, 3'b000, 1, 2'd3, mk(3'b110, 1, 1, 0, 3'd4));
        vecs[4]  = mv(1, 0, 3'b000, 0, 2'd0, mk(3'b110, 1, 1, 1, 3'd4));
        vecs[5]  = mv(0, 1, 3'b000, 0, 2'd0, mk(3'b110, 1, 1, 0, 3'd4));
        vecs[6]  = mv(1, 1, 3'b000, 0, 2'd0, mk(3'b110, 1, 1, 1, 3'd4));
        vecs[7]  = mv(0, 1, 3'b000, 0, 2'd0, mk(3'b110, 1, 1, 0, 3'd4));
        vecs[8]  = mv(1, 0, 3'b001, 0, 2'd0, mk(3'b110, 0, 1, 1, 3'd3));
        vecs[9]  = mv(1, 0, 3'b001, 1, 2'd0, mk(3'b111, 1, 1, 1, 3'd4));
        vecs[10] = mv(0, 1, 3'b001, 0, 2'd1, mk(3'b111, 1, 1, 0, 3'd4));
        vecs[11] = mv(1, 0, 3'b001, 0, 2'd1, mk(3'b111, 1, 1, 1, 3'd4));

        // Reset held with push high.
        l_rst    = 1'b0;
        push     = 1'b1;
        ovf_clr  = 1'b0;
        wq2_rptr = 3'b000;
        repeat (2) @(posedge l_clk);
        #1;
        chk_all_zero("rst_hold");
        l_rst = 1'b1;
        #1;
        chk("rel.wen",    wen,    1'b1);
        chk("rel.wptr",   wptr,   3'd0);
        chk("rel.full",   full,   1'b0);
        chk("rel.wcount", wcount, 3'd0);

        // Fill, overflow, clear, read step, refill.
        for (int i = 0; i < 12; i++)
            drive_cycle($sformatf("vec%0d", i), vecs[i].push, vecs[i].clr,
                        vecs[i].rptr, vecs[i].wen, vecs[i].waddr, vecs[i].e);

        // Asynchronous reset while full with overflow set.
        #2;
        l_rst = 1'b0;
        #1;
        chk_all_zero("async_rst_full");
        push     = 1'b0;
        ovf_clr  = 1'b0;
        wq2_rptr = 3'b000;
        @(posedge l_clk);
        #1;
        l_rst = 1'b1;

        // Eight pushes with the read pointer trailing the write pointer by two
        // cycles; the pointer must wrap to 000 without full or overflow.
        d1  = 3'b000;
        d2  = 3'b000;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            push     = (k < 8);
            wq2_rptr = d2;
            #1;
            chk($sformatf("trk%0d.wen", k), wen, (k < 8) ? 1'b1 : 1'b0);
            @(posedge l_clk);
            #1;
            if (k < 8) cnt++;
            gexp = 3'(cnt) ^ (3'(cnt) >> 1);
            chk($sformatf("trk%0d.wptr", k), wptr, gexp);
            chk($sformatf("trk%0d.full", k), full, 1'b0);
            chk($sformatf("trk%0d.ovf", k), overflow, 1'b0);
            d2 = d1;
            d1 = wptr;
        end
        chk("trk.final_wptr",   wptr,   3'b000);
        chk("trk.final_wcount", wcount, 3'd0);

        // Reset between push 2 and push 3.
        drive_cycle("mid_p1", 1, 0, 3'b000, 1, 2'd0, mk(3'b001, 0, 0, 0, 3'd1));
        drive_cycle("mid_p2", 1, 0, 3'b000, 1, 2'd1, mk(3'b011, 0, 0, 0, 3'd2));
        #2;
        l_rst = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(posedge l_clk);
        #1;
        chk_all_zero("mid_rst_edge");
        l_rst = 1'b1;
        drive_cycle("mid_p3", 1, 0, 3'b000, 1, 2'd0, mk(3'b001, 0, 0, 0, 3'd1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
